// File: rtl/dig_display_pkg.sv
// Shared constants and types for the 7-segment display blocks.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package dig_display_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    localparam logic [6:0] HEX7SEG [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef logic [2:0] digit_idx_t;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment pattern decoder.
module hex_to_7seg
    import dig_display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX7SEG[hex];

endmodule

// File: rtl/dig_display_scan.sv
// Time-multiplexed 8-digit common-anode display driver with a per-frame input latch.
// Anodes, segments and decimal point are registered and active-low.
module dig_display_scan
    import dig_display_pkg::*;
#(
    parameter int TICK_DIV = 100000,
    parameter int NDIG     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4*NDIG-1:0] digs,
    input  logic [NDIG-1:0]   blank,
    input  logic [NDIG-1:0]   dp,
    output logic [NDIG-1:0]   an,
    output logic [6:0]        seg,
    output logic              dp_n
);

    localparam int              CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TICK_DIV - 1);
    localparam digit_idx_t      IDX_LAST = digit_idx_t'(NDIG - 1);

    logic [CW-1:0]     cnt;
    digit_idx_t        idx;
    logic              loaded;
    logic              tick;
    logic              frame_load;

    logic [4*NDIG-1:0] shadow_digs;
    logic [NDIG-1:0]   shadow_blank;
    logic [NDIG-1:0]   shadow_dp;

    logic [3:0]        cur_hex;
    logic [6:0]        cur_seg;
    logic [NDIG-1:0]   an_d;
    logic [6:0]        seg_d;
    logic              dp_n_d;

    assign tick       = (cnt == CNT_LAST);
    assign frame_load = !loaded || (tick && (idx == IDX_LAST));

    // The prescaler holds during the first-load cycle so that digit 0 still
    // gets a full slot once the first latched frame becomes visible.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            idx    <= '0;
            loaded <= 1'b0;
        end else begin
            loaded <= 1'b1;
            if (loaded) begin
                if (tick) begin
                    cnt <= '0;
                    idx <= idx + 3'd1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_digs  <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '1;
        end else if (frame_load) begin
            shadow_digs  <= digs;
            shadow_dp    <= dp;
            shadow_blank <= blank;
        end
    end

    assign cur_hex = shadow_digs[{idx, 2'b00} +: 4];

    hex_to_7seg u_dec (
        .hex (cur_hex),
        .seg (cur_seg)
    );

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        an_d   = AN_OFF;
        seg_d  = SEG_OFF;
        dp_n_d = 1'b1;
        if (!shadow_blank[idx]) begin
            an_d   = ~(NDIG'(1) << idx);
            seg_d  = cur_seg;
            dp_n_d = ~shadow_dp[idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an   <= AN_OFF;
            seg  <= SEG_OFF;
            dp_n <= 1'b1;
        end else begin
            an   <= an_d;
            seg  <= seg_d;
            dp_n <= dp_n_d;
        end
    end

endmodule

// File: tb/tb_dig_display_scan.sv
// Self-checking bench for dig_display_scan: directed scenarios plus random
// input churn, compared against a time-based model of the scan.
module tb_dig_display_scan;

    localparam int TD = 4;
    localparam int FR = 8 * TD;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] digs;
    logic [7:0]  blank;
    logic [7:0]  dp;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp_n;

    always #5 clk = ~clk;

    dig_display_scan #(.TICK_DIV(TD), .NDIG(8)) dut (
        .clk   (clk),
        .reset (reset),
        .digs  (digs),
        .blank (blank),
        .dp    (dp),
        .an    (an),
        .seg   (seg),
        .dp_n  (dp_n)
    );

    int checks = 0;
    int errors = 0;

    // Reference: n counts clock edges since reset release. The frame seen by
    // the inputs at edge 1, 1+FR, 1+2*FR, ... is displayed from the next edge.
    int          n = 0;
    logic [31:0] sh_digs = '0, disp_digs = '0;
    logic [7:0]  sh_blank = '1, disp_blank = '1;
    logic [7:0]  sh_dp = '0, disp_dp = '0;

    logic [6:0] ref_seg [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int shown_digit();
        return ((n - 2) / TD) % 8;
    endfunction

    task automatic check_out(input string tag);
        logic [7:0] ea;
        logic [6:0] es;
        logic       ed;
        int         d;
        ea = 8'hFF;
        es = 7'h7F;
        ed = 1'b1;
        if (!reset && n >= 2) begin
            d = shown_digit();
            if (!disp_blank[d]) begin
                ea = ~(8'd1 << d);
                es = ref_seg[disp_digs[4*d +: 4]];
                ed = ~disp_dp[d];
            end
        end
        checks++;
        assert (an === ea) else begin
            errors++;
            $error("FAIL %s an (n=%0d): observed %h expected %h", tag, n, an, ea);
        end
        checks++;
        assert (seg === es) else begin
            errors++;
            $error("FAIL %s seg (n=%0d): observed %h expected %h", tag, n, seg, es);
        end
        checks++;
        assert (dp_n === ed) else begin
            errors++;
            $error("FAIL %s dp_n (n=%0d): observed %b expected %b", tag, n, dp_n, ed);
        end
        checks++;
        assert ($countones(~an) <= 1) else begin
            errors++;
            $error("FAIL %s onehot (n=%0d): observed an %h expected at most one low", tag, n, an);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (reset) begin
            n = 0;
        end else begin
            n++;
            disp_digs  = sh_digs;
            disp_blank = sh_blank;
            disp_dp    = sh_dp;
            if ((n - 1) % FR == 0) begin
                sh_digs  = digs;
                sh_blank = blank;
                sh_dp    = dp;
            end
        end
        @(negedge clk);
        check_out(tag);
    endtask

    task automatic run(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) step(tag);
    endtask

    // Advance until the given digit is on display, bounded by two frames.
    task automatic run_to_digit(input int d, input string tag);
        int budget;
        budget = 2 * FR;
        while (!(n >= 2 && shown_digit() == d) && budget > 0) begin
            step(tag);
            budget--;
        end
        checks++;
        assert (budget > 0) else begin
            errors++;
            $error("FAIL %s reach_digit: observed timeout expected digit %0d", tag, d);
        end
    endtask

    initial begin
        reset = 1'b1;
        digs  = $urandom;
        blank = 8'($urandom);
        dp    = 8'($urandom);
        #1;
        check_out("reset_init");

        // Reset hold with arbitrary inputs.
        for (int i = 0; i < 10; i++) begin
            digs  = $urandom;
            blank = 8'($urandom);
            dp    = 8'($urandom);
            step("reset_hold");
        end

        // Basic scan.
        digs  = 32'h0000_1234;
        blank = 8'h00;
        dp    = 8'h00;
        reset = 1'b0;
        run(2 * FR + 2, "basic_scan");

        // Frame coherency: change input while digit 3 is on display.
        run_to_digit(3, "coherency");
        digs = 32'hFEDC_BA98;
        run(FR + 8, "coherency");

        // Blanking.
        digs  = 32'h8888_8888;
        blank = 8'hF0;
        run(2 * FR, "blanking");

        // Decimal point, then decimal point on a blanked digit.
        blank = 8'h00;
        dp    = 8'h01;
        run(2 * FR, "dp");
        blank = 8'h01;
        run(2 * FR, "dp_blank");

        // Asynchronous reset while digit 5 is lit, asserted between edges.
        blank = 8'h00;
        dp    = 8'h00;
        digs  = 32'h7654_3210;
        run(FR, "pre_midreset");
        run_to_digit(5, "midreset");
        #2 reset = 1'b1;
        #1 check_out("midreset_async");
        run(3, "midreset_hold");
        reset = 1'b0;
        run(FR + 4, "midreset_restart");

        // Random input churn, including async reset pulses.
        for (int k = 0; k < 24; k++) begin
            digs  = $urandom;
            blank = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            dp    = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                #($urandom_range(1, 3)) reset = 1'b1;
                #1 check_out("rand_async_reset");
                run($urandom_range(1, 3), "rand_reset_hold");
                reset = 1'b0;
            end
            run($urandom_range(1, 45), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
